// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine and its serial multiplier.
package rsa_pkg;

  localparam int DEFAULT_BITS = 32;

  function automatic int cw_for(input int bits);
    return $clog2(bits) + 1;
  endfunction

  // Counter width for the default operand size; pass cw_for(BITS) when overriding BITS.
  localparam int CW = cw_for(DEFAULT_BITS);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    EXP,
    FIN
  } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Serial interleaved (shift-add) modular multiplier: P = A*B mod N, one bit of A per cycle, MSB first.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int CNT_W = CW
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [BITS-1:0] N,
  output logic [BITS-1:0] P,
  output logic            DONE
);

  logic [BITS-1:0]  a_q, b_q, n_q, p_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [BITS-1:0]  src_a, src_b, src_n, src_p, p_step;

  // One BITS+1 wide step keeps 2P and P+B (both < 2N) free of overflow.
  function automatic logic [BITS-1:0] mod_step(input logic [BITS-1:0] p, input logic abit,
                                                input logic [BITS-1:0] b, input logic [BITS-1:0] n);
    logic [BITS:0] t, nn;
    // NOTE: blocking assignments here are sequential temporaries inside combinational math.
    nn = {1'b0, n};
    t  = {p, 1'b0};
    if (t >= nn) t = t - nn;
    if (abit) begin
      t = t + {1'b0, b};
      if (t >= nn) t = t - nn;
    end
    return t[BITS-1:0];
  endfunction

  // The first step runs in the START cycle itself, so a product takes exactly BITS cycles.
  always_comb begin
    src_a  = START ? A  : a_q;
    src_b  = START ? B  : b_q;
    src_n  = START ? N  : n_q;
    src_p  = START ? '0 : p_q;
    p_step = mod_step(src_p, src_a[BITS-1], src_b, src_n);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      P     <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (START) begin
        a_q   <= A << 1;
        b_q   <= B;
        n_q   <= N;
        p_q   <= p_step;
        cnt_q <= CNT_W'(BITS - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        a_q   <= a_q << 1;
        p_q   <= p_step;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_q <= 1'b0;
          DONE  <= 1'b1;
          P     <= p_step;
        end
      end
    end
  end

endmodule

// File: rtl/rsa_modexp_engine.sv
// RSA responder: RESULT = M^E mod N by right-to-left square-and-multiply on two serial multipliers.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int BITS  = DEFAULT_BITS,
  parameter int CNT_W = CW
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            LOAD,
  input  logic            GO,
  input  logic [BITS-1:0] M,
  input  logic [BITS-1:0] E,
  input  logic [BITS-1:0] N,
  output logic [BITS-1:0] RESULT,
  output logic            DONE,
  output logic            BUSY,
  output logic            ERR
);

  state_t           state_q, state_d;
  logic [BITS-1:0]  m_q, e_q, n_q;
  logic [BITS-1:0]  r_q, b_q, exp_q;
  logic [CNT_W-1:0] iter_q;
  logic             loaded_q;

  logic             start_run, n_zero, step_done;
  logic             mul0_start, mul1_start;
  logic [BITS-1:0]  r_next, b_next, mul0_a, mul0_b;
  logic [BITS-1:0]  p0, p1;
  logic             done0, done1;

  // LOAD has priority, and a finished result blocks restarts until the next LOAD.
  assign start_run = GO && !LOAD && loaded_q && !DONE;
  assign n_zero    = (n_q == '0);
  assign step_done = done0 && done1;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    mul0_start = 1'b0;
    mul1_start = 1'b0;
    r_next     = r_q;
    b_next     = b_q;
    unique case (state_q)
      IDLE: begin
        if (state_q == IDLE && start_run) begin
          if (n_zero) begin
            state_d = FIN;
          end else begin
            state_d    = REDUCE;
            mul0_start = 1'b1;
          end
        end
      end
      REDUCE: begin
        if (done0) begin
          b_next     = p0;
          state_d    = EXP;
          mul0_start = 1'b1;
          mul1_start = 1'b1;
        end
      end
      EXP: begin
        if (step_done) begin
          if (exp_q[0]) r_next = p0;
          b_next = p1;
          if (iter_q == CNT_W'(BITS - 1)) begin
            state_d = FIN;
          end else begin
            mul0_start = 1'b1;
            mul1_start = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Operands come from the next-state values so each iteration starts back to back.
    mul0_a = (state_q == IDLE) ? m_q : r_next;
    mul0_b = (state_q == IDLE) ? BITS'(1) : b_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      m_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      iter_q   <= '0;
      loaded_q <= 1'b0;
      RESULT   <= '0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (LOAD) begin
            m_q      <= M;
            e_q      <= E;
            n_q      <= N;
            loaded_q <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
          end else if (start_run) begin
            r_q    <= (n_q > BITS'(1)) ? BITS'(1) : '0;
            exp_q  <= e_q;
            iter_q <= '0;
            BUSY   <= !n_zero;
          end
        end
        REDUCE: b_q <= b_next;
        EXP: begin
          r_q <= r_next;
          b_q <= b_next;
          if (step_done) begin
            exp_q  <= exp_q >> 1;
            iter_q <= iter_q + CNT_W'(1);
          end
        end
        FIN: begin
          RESULT <= r_q;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
          ERR    <= n_zero;
        end
        default: ;
      endcase
    end
  end

  rsa_modmul #(.BITS(BITS), .CNT_W(CNT_W)) u_mul0 (
    .CLK  (CLK),
    .RESET(RESET),
    .START(mul0_start),
    .A    (mul0_a),
    .B    (mul0_b),
    .N    (n_q),
    .P    (p0),
    .DONE (done0)
  );

  rsa_modmul #(.BITS(BITS), .CNT_W(CNT_W)) u_mul1 (
    .CLK  (CLK),
    .RESET(RESET),
    .START(mul1_start),
    .A    (b_next),
    .B    (b_next),
    .N    (n_q),
    .P    (p1),
    .DONE (done1)
  );

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Scoreboard bench for rsa_modexp_engine: directed cases plus random operands against an arithmetic model.
module tb_rsa_modexp_engine;

  localparam int BITS = 32;
  localparam int LAT  = 1 + BITS * (BITS + 1);

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            LOAD = 1'b0;
  logic            GO = 1'b0;
  logic [BITS-1:0] M = '0, E = '0, N = '0;
  logic [BITS-1:0] RESULT;
  logic            DONE, BUSY, ERR;

  typedef struct {
    logic [BITS-1:0] result;
    logic            err;
    int              done_cyc;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  logic            done_prev = 1'b0;
  logic [BITS-1:0] cur_m = '0, cur_e = '0, cur_n = '0;

  rsa_modexp_engine #(.BITS(BITS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (LOAD),
    .GO    (GO),
    .M     (M),
    .E     (E),
    .N     (N),
    .RESULT(RESULT),
    .DONE  (DONE),
    .BUSY  (BUSY),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [BITS-1:0] ref_modexp(input logic [BITS-1:0] m, input logic [BITS-1:0] e,
                                                  input logic [BITS-1:0] n);
    longint unsigned md, r, b;
    logic [BITS-1:0] x;
    if (n == '0) return '0;
    md = 64'(n);
    r  = 64'd1 % md;
    b  = 64'(m) % md;
    x  = e;
    for (int i = 0; i < BITS; i++) begin
      if (x[0]) r = (r * b) % md;
      b = (b * b) % md;
      x = x >> 1;
    end
    return r[BITS-1:0];
  endfunction

  // Monitor: every rising DONE consumes one expected run.
  always @(negedge CLK) begin
    if (DONE && !done_prev) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(DONE), 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("result", 64'(RESULT), 64'(x.result));
        check("err", 64'(ERR), 64'(x.err));
        check("latency", 64'(cyc), 64'(x.done_cyc));
        check("busy_at_done", 64'(BUSY), 64'd0);
      end
    end
    done_prev = DONE;
  end

  task automatic load_ops(input logic [BITS-1:0] m, input logic [BITS-1:0] e, input logic [BITS-1:0] n);
    @(negedge CLK);
    M = m; E = e; N = n; LOAD = 1'b1;
    cur_m = m; cur_e = e; cur_n = n;
    @(negedge CLK);
    LOAD = 1'b0;
    check("load_clears_done", 64'(DONE), 64'd0);
    check("load_clears_err", 64'(ERR), 64'd0);
  endtask

  task automatic start_run(input logic hold);
    exp_t x;
    @(negedge CLK);
    GO = 1'b1;
    x.result   = ref_modexp(cur_m, cur_e, cur_n);
    x.err      = (cur_n == '0);
    x.done_cyc = cyc + 1 + ((cur_n == '0) ? 1 : LAT);
    sb.push_back(x);
    if (!hold) begin
      @(negedge CLK);
      GO = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!DONE && n < LAT + 50) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_done_timeout"}, 64'(DONE), 64'd1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("rst_result", 64'(RESULT), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);

    // GO before any LOAD must not start anything.
    @(negedge CLK); GO = 1'b1;
    repeat (3) @(negedge CLK);
    check("go_unloaded_busy", 64'(BUSY), 64'd0);
    GO = 1'b0;

    // Encrypt with GO held through DONE: no restart.
    load_ops(32'd190, 32'd3, 32'd1189);
    start_run(1'b1);
    wait_done("enc");
    repeat (5) @(negedge CLK);
    check("held_go_done", 64'(DONE), 64'd1);
    check("held_go_busy", 64'(BUSY), 64'd0);
    check("held_go_result", 64'(RESULT), 64'd848);
    GO = 1'b0;

    // Decrypt round trip, then a second GO without LOAD.
    load_ops(32'd848, 32'd187, 32'd1189);
    start_run(1'b0);
    wait_done("dec");
    @(negedge CLK); GO = 1'b1;
    repeat (4) @(negedge CLK);
    check("rego_busy", 64'(BUSY), 64'd0);
    check("rego_done", 64'(DONE), 64'd1);
    check("rego_result", 64'(RESULT), 64'd190);
    GO = 1'b0;

    // Boundary operands: M >= N, E = 0, N = 1, N = 0.
    load_ops(32'd1379, 32'd3, 32'd1189);  start_run(1'b0); wait_done("m_ge_n");
    load_ops(32'd5, 32'd0, 32'd1189);     start_run(1'b0); wait_done("e_zero");
    load_ops(32'd7, 32'd9, 32'd1);        start_run(1'b0); wait_done("n_one");
    load_ops(32'd7, 32'd9, 32'd0);        start_run(1'b0); wait_done("n_zero");
    load_ops(32'd190, 32'd3, 32'd1189);   // LOAD after an N=0 run clears ERR/DONE (checked in load_ops)

    // RESET in the middle of a run.
    start_run(1'b0);
    repeat (498) @(negedge CLK);
    check("mid_busy", 64'(BUSY), 64'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    check("abort_result", 64'(RESULT), 64'd0);
    check("abort_done", 64'(DONE), 64'd0);
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_err", 64'(ERR), 64'd0);
    load_ops(32'd190, 32'd3, 32'd1189);
    start_run(1'b0);
    wait_done("after_abort");

    // LOAD/GO activity while BUSY is ignored.
    load_ops(32'd190, 32'd3, 32'd1189);
    start_run(1'b0);
    repeat (10) @(negedge CLK);
    check("busy_during_run", 64'(BUSY), 64'd1);
    M = 32'd1; E = 32'd1; N = 32'd7; LOAD = 1'b1; GO = 1'b1;
    @(negedge CLK); LOAD = 1'b0; GO = 1'b0;
    @(negedge CLK); GO = 1'b1;
    @(negedge CLK); GO = 1'b0;
    wait_done("busy_ignore");

    // Random operands, some with the top modulus bit set.
    for (int i = 0; i < 14; i++) begin
      logic [BITS-1:0] rm, re, rn;
      rm = $urandom;
      re = $urandom;
      case (i % 3)
        0:       rn = $urandom | 32'h8000_0001;
        1:       rn = 32'($urandom_range(2, 5000));
        default: rn = $urandom;
      endcase
      load_ops(rm, re, rn);
      start_run(1'b0);
      wait_done("random");
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
- Hardware responder for the RSA test stimulus controller.
- Captures message M, exponent E and modulus N on LOAD; on GO computes RESULT = M^E mod N; raises DONE and holds it.
- Uses right-to-left square-and-multiply over two serial interleaved (shift-add) modular multipliers.
- Sits between the stimulus/pushbutton controller and the display/memory path.

Parameters:
- BITS, 32, operand width of M, E, N and RESULT.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- LOAD  input  1  capture M/E/N into operand registers (level, sampled each cycle)
- GO  input  1  start request (level)
- M  input  BITS  message
- E  input  BITS  exponent
- N  input  BITS  modulus
- RESULT  output  BITS  M^E mod N, valid while DONE=1
- DONE  output  1  computation complete (sticky)
- BUSY  output  1  computation in progress
- ERR  output  1  last run had N==0

Behaviour:
- Clock/reset: one clock (CLK); RESET is synchronous and active-high.
- Reset: state=IDLE; RESULT=0, DONE=0, BUSY=0, ERR=0; operand registers=0; loaded flag=0.
- RESET mid-operation aborts within one cycle. No partial RESULT is ever exposed.
- IDLE:
  - LOAD=1: capture M, E, N; set loaded flag; clear DONE and ERR. RESULT keeps its value.
  - GO=1 with loaded flag set and DONE=0: start. If LOAD and GO are both high, LOAD wins and GO is ignored that cycle.
  - GO with DONE=1 or loaded flag clear is ignored. A new run therefore requires a new LOAD.
- Start with N==0: go to FIN next cycle; RESULT=0, ERR=1.
- Start with N!=0:
  - R = (N==1) ? 0 : 1
  - e = E
  - BUSY=1
  - enter REDUCE.
- REDUCE (BITS cycles): B = M*1 mod N via multiplier 0. Handles M>=N.
- EXP (BITS iterations of BITS cycles each):
  - Both multipliers run in parallel: mul0 computes R*B mod N, mul1 computes B*B mod N.
  - At the end of an iteration: R updates only if e[0]=1; B always updates; e shifts right by 1.
  - All BITS exponent bits are processed (no early exit), so latency is fixed.
- FIN: RESULT=R, DONE=1, BUSY=0.
  - Return to IDLE with DONE held high until the next LOAD or RESET.
  - This matches the controller's "drop GO when DONE" rule.
- Latency: GO sampled at edge k gives DONE=1 after edge k+1+BITS*(BITS+1). That is 1057 cycles for BITS=32.
- LOAD or GO while BUSY: ignored. Operand registers are frozen during a run.
- Multiplier (per cycle, bits of A taken MSB first):
  - P = 2P; if P>=N then P=P-N
  - if A[i]=1 then P = P+B; if P>=N then P=P-N
- Multiplier preconditions: B<N and P<N. Intermediates are BITS+1 wide, so there is no overflow for any N up to 2^BITS-1.
- Multiplier outputs are registered and a one-cycle done pulse is issued after BITS cycles.

Decomposition:
- Shared package rsa_pkg holds:
  - BITS default
  - state encoding IDLE/REDUCE/EXP/FIN
  - counter width CW = $clog2(BITS)+1
- Sub-module rsa_modmul is the serial interleaved modular multiplier.
  - Ports: CLK, RESET, START, A, B, N, P, DONE.
  - The engine instantiates it twice.

Test Plan:
- RESET, LOAD M=190 E=3 N=1189, GO held -> DONE rises exactly 1057 cycles after GO sample; RESULT=848; ERR=0; DONE stays high with GO still high; no restart.
- LOAD M=848 E=187 N=1189, GO -> RESULT=190 (decrypt round-trip). Second GO without LOAD is ignored; DONE stays 1.
- LOAD M=1379 (>=N) E=3 N=1189 -> RESULT=848. Also E=0, M=5, N=1189 -> RESULT=1; M=7, E=9, N=1 -> RESULT=0.
- LOAD N=0, GO -> DONE=1 two cycles after GO sample, RESULT=0, ERR=1. Next LOAD clears DONE and ERR.
- Start M=190 E=3 N=1189, assert RESET at cycle 500 -> next cycle all outputs 0, state IDLE. LOAD+GO afterwards -> RESULT=848 with full latency.
- While BUSY, pulse LOAD with M=1 E=1 N=7 and toggle GO -> ignored; RESULT=848 from the original operands.
